// File: rtl/mdu_iter_if.sv
// Request/response bundle between the core and the iterative RV32M multiply/divide unit.
// The core drives the request side (master); the unit drives busy/done/res (slave).
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             kill;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;

    modport master (output start, kill, funct3, a, b, input busy, done, res);
    modport slave  (input start, kill, funct3, a, b, output busy, done, res);
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide on magnitudes,
// 32 steps each. Optional macro MDU_EARLY_OUT_EN finishes divide-by-zero and signed overflow in 1 cycle.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    mdu_iter_if.slave   bus
);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   res_reg;
    logic [4:0]         cnt_reg;
    logic [2:0]         op_reg;
    logic               neg_reg;
    logic               special_reg;
    logic [WIDTH-1:0]   spec_res_reg;
    logic [WIDTH-1:0]   opnd_reg;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_reg;       // {product hi, multiplier} or {remainder, dividend}

    // Operand decode for a new request
    logic             a_sgn, b_sgn, a_neg, b_neg, sign_in;
    logic             is_div0, is_ovf, is_special;
    logic [WIDTH-1:0] a_mag, b_mag, spec_res;

    always_comb begin
        a_sgn      = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                     (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_sgn      = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        a_neg      = a_sgn && bus.a[WIDTH-1];
        b_neg      = b_sgn && bus.b[WIDTH-1];
        a_mag      = a_neg ? (~bus.a + 1'b1) : bus.a;
        b_mag      = b_neg ? (~bus.b + 1'b1) : bus.b;
        // Remainder takes the dividend's sign; quotient and product take the XOR.
        sign_in    = (bus.funct3[2] && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
        is_div0    = bus.funct3[2] && (bus.b == '0);
        is_ovf     = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
                     (bus.a == MIN_NEG) && (bus.b == '1);
        is_special = is_div0 || is_ovf;
        if (is_div0)
            spec_res = bus.funct3[1] ? bus.a : '1;
        else
            spec_res = bus.funct3[1] ? '0 : MIN_NEG;
    end

    // One iteration step plus the sign-fixed result it would produce
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   div_sel, mul_res, div_res, final_res;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
        div_diff  = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_reg};
        div_next  = div_diff[WIDTH] ? {acc_reg[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        step_next = op_reg[2] ? div_next : mul_next;
        prod_fix  = neg_reg ? (~step_next + 1'b1) : step_next;
        mul_res   = (op_reg[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        div_sel   = op_reg[1] ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
        div_res   = neg_reg ? (~div_sel + 1'b1) : div_sel;
        final_res = special_reg ? spec_res_reg : (op_reg[2] ? div_res : mul_res);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            res_reg      <= '0;
            cnt_reg      <= '0;
            op_reg       <= '0;
            neg_reg      <= 1'b0;
            special_reg  <= 1'b0;
            spec_res_reg <= '0;
            opnd_reg     <= '0;
            acc_reg      <= '0;
        end else if (bus.kill) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                CALC: begin
                    acc_reg <= step_next;
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        res_reg   <= final_res;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        op_reg       <= bus.funct3;
                        neg_reg      <= sign_in;
                        special_reg  <= is_special;
                        spec_res_reg <= spec_res;
                        opnd_reg     <= bus.funct3[2] ? b_mag : a_mag;
                        acc_reg      <= {{WIDTH{1'b0}}, (bus.funct3[2] ? a_mag : b_mag)};
                        cnt_reg      <= '0;
`ifdef MDU_EARLY_OUT_EN
                        if (is_special) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            res_reg   <= spec_res;
                        end else begin
                            state_reg <= CALC;
                            busy_reg  <= 1'b1;
                        end
`else
                        state_reg <= CALC;
                        busy_reg  <= 1'b1;
`endif
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.res  = res_reg;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vectors, corner sequences and randomized ops
// compared against an arithmetic reference model.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(32)) bus();
    mdu_iter #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q;
        logic [63:0] p;
        logic [31:0] r;
        sa = (f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd6) ? longint'($signed(a)) : longint'({32'b0, a});
        sb = (f == 3'd1 || f == 3'd4 || f == 3'd6) ? longint'($signed(b)) : longint'({32'b0, b});
        r = '0;
        if (!f[2]) begin
            p = sa * sb;
            r = (f == 3'd0) ? p[31:0] : p[63:32];
        end else if (b == 0) begin
            r = f[1] ? a : 32'hFFFF_FFFF;
        end else if ((f == 3'd4 || f == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) begin
            r = f[1] ? 32'h0 : MIN_NEG;
        end else begin
            q = f[1] ? (sa % sb) : (sa / sb);
            r = q[31:0];
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        if (f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF)))
            return 1;
`endif
        return 33;
    endfunction

    // Drive a request at a falling edge; it is sampled on the next rising edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.a      = a;
        bus.b      = b;
    endtask

    // Count falling edges from the sampling edge until done; returns latency and busy-cycle count.
    task automatic wait_done(output logic [31:0] r, output int lat, output int busy_cnt, output logic busy_at_done);
        lat = 0;
        busy_cnt = 0;
        busy_at_done = 1'b1;
        r = '0;
        @(posedge clk);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                lat = i;
                r = bus.res;
                busy_at_done = bus.busy;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
        if (lat == 0) chk("done_timeout", 32'(lat), 32'd33);
    endtask

    vec_t vecs[12];
    logic [31:0] r, prev, ra, rb;
    logic [2:0] rf;
    logic bad;
    int lat, bcnt, ndone;

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC};
        vecs[7]  = '{3'd7, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001};
        vecs[8]  = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF};
        vecs[9]  = '{3'd6, 32'd5, 32'd0, 32'd5};
        vecs[10] = '{3'd4, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG};
        vecs[11] = '{3'd6, MIN_NEG, 32'hFFFF_FFFF, 32'h0};

        bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("reset_done", {31'b0, bus.done}, 32'd0);
        chk("reset_res", bus.res, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b);
            wait_done(r, lat, bcnt, bad);
            $display("vec %0d f=%0d a=%08h b=%08h res=%08h lat=%0d", i, vecs[i].f, vecs[i].a, vecs[i].b, r, lat);
            chk($sformatf("vec%0d_res", i), r, vecs[i].exp);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].f, vecs[i].a, vecs[i].b)));
            chk($sformatf("vec%0d_busycycles", i), 32'(bcnt), 32'(exp_lat(vecs[i].f, vecs[i].a, vecs[i].b) - 1));
            chk($sformatf("vec%0d_busy_at_done", i), {31'b0, bad}, 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), {31'b0, bus.done}, 32'd0);
        end

        // Back-to-back: second start during the first done cycle
        issue(3'd3, 32'd3, 32'd5);
        wait_done(r, lat, bcnt, bad);
        $display("b2b first res=%08h lat=%0d", r, lat);
        chk("b2b_first_res", r, 32'd0);
        issue(3'd5, 32'd100, 32'd7);
        wait_done(r, lat, bcnt, bad);
        $display("b2b second res=%08h lat=%0d", r, lat);
        chk("b2b_second_res", r, 32'd14);
        chk("b2b_second_lat", 32'(lat), 32'd33);
        @(negedge clk);

        // start while busy must not disturb the latched operands
        issue(3'd0, 32'd1234, 32'd5678);
        @(posedge clk);
        repeat (5) @(negedge clk);
        issue(3'd5, 32'd99, 32'd3);
        @(negedge clk);
        bus.start = 1'b0;
        r = '0; lat = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done) begin r = bus.res; lat = 1; break; end
            @(negedge clk);
        end
        $display("interfere res=%08h", r);
        chk("interfere_done_seen", 32'(lat), 32'd1);
        chk("interfere_res", r, 32'd1234 * 32'd5678);
        @(negedge clk);
        chk("interfere_no_extra_busy", {31'b0, bus.busy}, 32'd0);

        // kill at cycle T+10
        prev = bus.res;
        issue(3'd4, 32'd1000, 32'd3);
        @(posedge clk);
        repeat (10) @(negedge clk);
        bus.start = 1'b0;
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        chk("kill_busy", {31'b0, bus.busy}, 32'd0);
        chk("kill_res_held", bus.res, prev);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        $display("kill res=%08h dones=%0d", bus.res, ndone);
        chk("kill_no_done", 32'(ndone), 32'd0);
        chk("kill_res_after", bus.res, prev);

        // kill wins over a simultaneous start
        issue(3'd0, 32'd3, 32'd3);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.kill = 1'b0;
        chk("kill_vs_start_busy", {31'b0, bus.busy}, 32'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 5) == 0) ? MIN_NEG : $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            @(negedge clk);
            issue(rf, ra, rb);
            wait_done(r, lat, bcnt, bad);
            $display("rand %0d f=%0d a=%08h b=%08h res=%08h lat=%0d", i, rf, ra, rb, r, lat);
            chk($sformatf("rand%0d_res", i), r, ref_mdu(rf, ra, rb));
            chk($sformatf("rand%0d_lat", i), 32'(lat), 32'(exp_lat(rf, ra, rb)));
        end

        // Asynchronous reset mid-CALC
        @(negedge clk);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk);
        repeat (10) @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_done", {31'b0, bus.done}, 32'd0);
        chk("arst_res", bus.res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        $display("arst dones=%0d res=%08h", ndone, bus.res);
        chk("arst_no_done", 32'(ndone), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
